// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned RegIdxW   = 5;
  localparam int unsigned StallCntW = 16;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StIwait   = 2'd1,
    StDwait   = 2'd2,
    StIllegal = 2'd3
  } state_e;

  // Write enables and bubble requests for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_m_write;
    logic m_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_m_flush;
    logic m_wb_flush;
    logic pc_sel_target;
    logic imem_abort;
  } ctrl_t;

  function automatic ctrl_t ctrl_advance();
    ctrl_t c;
    c               = '0;
    c.pc_write      = 1'b1;
    c.if_id_write   = 1'b1;
    c.id_ex_write   = 1'b1;
    c.ex_m_write    = 1'b1;
    c.m_wb_write    = 1'b1;
    return c;
  endfunction

  // Everything upstream of M/WB freezes; M/WB takes a bubble each cycle.
  function automatic ctrl_t ctrl_dmem_wait();
    ctrl_t c;
    c            = '0;
    c.m_wb_write = 1'b1;
    c.m_wb_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c             = '0;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    c.ex_m_flush  = 1'b1;
    c.m_wb_flush  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID sources and the load destination in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [RegIdxW-1:0] i_rs1_index,
  input  logic [RegIdxW-1:0] i_rs2_index,
  input  logic [RegIdxW-1:0] i_ex_rd_index,
  input  logic               i_ex_mem_read,
  output logic               o_load_use
);

  logic w_rd_nonzero;
  logic w_src_match;

  // x0 is never a real destination, so a load to it cannot create a hazard.
  assign w_rd_nonzero = (i_ex_rd_index != '0);
  assign w_src_match  = (i_ex_rd_index == i_rs1_index) || (i_ex_rd_index == i_rs2_index);
  assign o_load_use   = i_ex_mem_read && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall/flush/redirect decode, fetch/data wait FSM and stall counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RegIdxW-1:0]   id_rs1_index,
  input  logic [RegIdxW-1:0]   id_rs2_index,
  input  logic [RegIdxW-1:0]   ex_rgD_index,
  input  logic                 ex_mem_read,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 stall_clear,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_write,
  output logic                 ex_m_write,
  output logic                 m_wb_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_m_flush,
  output logic                 m_wb_flush,
  output logic                 pc_sel_target,
  output logic                 imem_abort,
  output logic [1:0]           state,
  output logic [StallCntW-1:0] stall_cycles
);

  localparam logic [StallCntW-1:0] StallMax = '1;

  state_e                r_state;
  state_e                w_state_next;
  logic [StallCntW-1:0]  r_stall_cycles;
  ctrl_t                 w_ctrl_fsm;
  ctrl_t                 w_ctrl;
  logic                  w_load_use;
  logic                  w_dmem_miss;

  hazard_detect u_hazard_detect (
    .i_rs1_index   (id_rs1_index),
    .i_rs2_index   (id_rs2_index),
    .i_ex_rd_index (ex_rgD_index),
    .i_ex_mem_read (ex_mem_read),
    .o_load_use    (w_load_use)
  );

  assign w_dmem_miss = dmem_req && !dmem_ready;

  always_comb begin
    w_ctrl_fsm   = ctrl_advance();
    w_state_next = StRun;
    case (r_state)
      StDwait: begin
        // Only the data memory can release this state; a completing access resumes in RUN.
        if (!dmem_ready) begin
          w_ctrl_fsm   = ctrl_dmem_wait();
          w_state_next = StDwait;
        end
      end
      default: begin
        // RUN, IWAIT and the illegal encoding share one priority chain.
        if (w_dmem_miss) begin
          w_ctrl_fsm   = ctrl_dmem_wait();
          w_state_next = StDwait;
        end else if (branch_taken) begin
          w_ctrl_fsm.pc_sel_target = 1'b1;
          w_ctrl_fsm.if_id_flush   = 1'b1;
          w_ctrl_fsm.id_ex_flush   = 1'b1;
          w_ctrl_fsm.ex_m_flush    = 1'b1;
          w_ctrl_fsm.imem_abort    = (r_state == StIwait);
        end else if (w_load_use) begin
          w_ctrl_fsm.pc_write    = 1'b0;
          w_ctrl_fsm.if_id_write = 1'b0;
          w_ctrl_fsm.id_ex_flush = 1'b1;
          w_state_next           = (r_state == StIwait) ? StIwait : StRun;
        end else if (!imem_ready) begin
          w_ctrl_fsm.pc_write    = 1'b0;
          w_ctrl_fsm.if_id_flush = 1'b1;
          w_state_next           = StIwait;
        end
      end
    endcase
  end

  // Reset forces a quiescent, all-bubble pipeline regardless of the FSM decode.
  assign w_ctrl = reset ? ctrl_reset() : w_ctrl_fsm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StRun;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      if (stall_clear) begin
        r_stall_cycles <= '0;
      end else if (!w_ctrl.pc_write && (r_stall_cycles != StallMax)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign pc_write      = w_ctrl.pc_write;
  assign if_id_write   = w_ctrl.if_id_write;
  assign id_ex_write   = w_ctrl.id_ex_write;
  assign ex_m_write    = w_ctrl.ex_m_write;
  assign m_wb_write    = w_ctrl.m_wb_write;
  assign if_id_flush   = w_ctrl.if_id_flush;
  assign id_ex_flush   = w_ctrl.id_ex_flush;
  assign ex_m_flush    = w_ctrl.ex_m_flush;
  assign m_wb_flush    = w_ctrl.m_wb_flush;
  assign pc_sel_target = w_ctrl.pc_sel_target;
  assign imem_abort    = w_ctrl.imem_abort;
  assign state         = r_state;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  // {pc,if_id,id_ex,ex_m,m_wb writes, if_id,id_ex,ex_m,m_wb flushes, pc_sel_target, imem_abort}
  localparam logic [10:0] CNorm  = 11'b11111_0000_0_0;
  localparam logic [10:0] CRst   = 11'b00000_1111_0_0;
  localparam logic [10:0] CDmiss = 11'b00001_0001_0_0;
  localparam logic [10:0] CBr    = 11'b11111_1110_1_0;
  localparam logic [10:0] CBrIw  = 11'b11111_1110_1_1;
  localparam logic [10:0] CLu    = 11'b00111_0100_0_0;
  localparam logic [10:0] CImiss = 11'b01111_1000_0_0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1_index = '0;
  logic [4:0]  id_rs2_index = '0;
  logic [4:0]  ex_rgD_index = '0;
  logic        ex_mem_read = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b1;
  logic        dmem_req = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        stall_clear = 1'b0;
  logic        pc_write, if_id_write, id_ex_write, ex_m_write, m_wb_write;
  logic        if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush;
  logic        pc_sel_target, imem_abort;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1_index  (id_rs1_index),
    .id_rs2_index  (id_rs2_index),
    .ex_rgD_index  (ex_rgD_index),
    .ex_mem_read   (ex_mem_read),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .stall_clear   (stall_clear),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_write   (id_ex_write),
    .ex_m_write    (ex_m_write),
    .m_wb_write    (m_wb_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_m_flush    (ex_m_flush),
    .m_wb_flush    (m_wb_flush),
    .pc_sel_target (pc_sel_target),
    .imem_abort    (imem_abort),
    .state         (state),
    .stall_cycles  (stall_cycles)
  );

  wire [10:0] obs = {pc_write, if_id_write, id_ex_write, ex_m_write, m_wb_write,
                     if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush, pc_sel_target, imem_abort};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [10:0] exp);
    #1;
    chk({tag, "_ctrl"}, {5'd0, obs}, {5'd0, exp});
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp_st, input logic [15:0] exp_cnt);
    chk({tag, "_state"}, {14'd0, state}, {14'd0, exp_st});
    chk({tag, "_stall"}, stall_cycles, exp_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic memrd, input logic br, input logic imr,
                        input logic dreq, input logic drdy, input logic clr);
    id_rs1_index = rs1;
    id_rs2_index = rs2;
    ex_rgD_index = rd;
    ex_mem_read  = memrd;
    branch_taken = br;
    imem_ready   = imr;
    dmem_req     = dreq;
    dmem_ready   = drdy;
    stall_clear  = clr;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset holds everything quiet even while a fetch miss is presented.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_ctrl("reset", CRst);
    chk_st("reset", 2'd0, 16'd0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk_ctrl("normal", CNorm);
    tick();
    chk_st("normal", 2'd0, 16'd0);

    // Load-use on rs2, then the bubble clears it.
    set_in(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("lu_rs2", CLu);
    tick();
    chk_st("lu_rs2", 2'd0, 16'd1);
    set_in(5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("lu_done", CNorm);
    tick();
    chk_st("lu_done", 2'd0, 16'd1);

    set_in(5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("lu_x0", CNorm);
    tick();
    chk_st("lu_x0", 2'd0, 16'd1);

    set_in(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("lu_rs1", CLu);
    tick();
    chk_st("lu_rs1", 2'd0, 16'd2);

    set_in(5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("no_load", CNorm);
    tick();
    chk_st("no_load", 2'd0, 16'd2);

    // Clear wins over the increment of a fetch-miss cycle.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctrl("imiss_clr", CImiss);
    tick();
    chk_st("imiss_clr", 2'd1, 16'd0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("iwait_hold", CImiss);
    tick();
    chk_st("iwait_hold", 2'd1, 16'd1);

    set_in(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("iwait_lu", CLu);
    tick();
    chk_st("iwait_lu", 2'd1, 16'd2);

    // Branch outranks load-use and aborts the outstanding fetch.
    set_in(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("iwait_br", CBrIw);
    tick();
    chk_st("iwait_br", 2'd0, 16'd2);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("run_br", CBr);
    tick();
    chk_st("run_br", 2'd0, 16'd2);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("imiss", CImiss);
    tick();
    chk_st("imiss", 2'd1, 16'd3);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("iwait_exit", CNorm);
    tick();
    chk_st("iwait_exit", 2'd0, 16'd3);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ctrl("clear", CNorm);
    tick();
    chk_st("clear", 2'd0, 16'd0);

    // Three miss cycles, the middle one also presenting branch/load-use/fetch miss.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctrl("dmiss1", CDmiss);
    tick();
    chk_st("dmiss1", 2'd2, 16'd1);
    set_in(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("dmiss2", CDmiss);
    tick();
    chk_st("dmiss2", 2'd2, 16'd2);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctrl("dmiss3", CDmiss);
    tick();
    chk_st("dmiss3", 2'd2, 16'd3);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_ctrl("dready", CNorm);
    tick();
    chk_st("dready", 2'd0, 16'd3);

    // Branch with a data miss waits; the held branch is applied back in RUN.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctrl("br_dmiss", CDmiss);
    tick();
    chk_st("br_dmiss", 2'd2, 16'd4);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_ctrl("br_dready", CNorm);
    tick();
    chk_st("br_dready", 2'd0, 16'd4);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctrl("br_after", CBr);
    tick();
    chk_st("br_after", 2'd0, 16'd4);

    // Data miss during IWAIT, then the fetch is re-evaluated from RUN.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("iw_pre", CImiss);
    tick();
    chk_st("iw_pre", 2'd1, 16'd5);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctrl("iw_dmiss", CDmiss);
    tick();
    chk_st("iw_dmiss", 2'd2, 16'd6);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_ctrl("iw_dready", CNorm);
    tick();
    chk_st("iw_dready", 2'd0, 16'd6);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctrl("iw_refetch", CImiss);
    tick();
    chk_st("iw_refetch", 2'd1, 16'd7);

    // Reset inside IWAIT with a branch pending: no abort, and RUN rules after release.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    chk_ctrl("rst_iwait", CRst);
    chk_st("rst_iwait", 2'd0, 16'd0);
    tick();
    reset = 1'b0;
    chk_ctrl("rst_release", CBr);
    tick();
    chk_st("rst_release", 2'd0, 16'd0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) tick();
    chk_st("sat", 2'd1, 16'hFFFF);
    tick();
    chk_st("sat_hold", 2'd1, 16'hFFFF);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_st("sat_clr", 2'd1, 16'd0);

    // Asynchronous reset mid-DWAIT, checked before the next rising edge.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("pre_rst_dwait", 2'd2, 16'd1);
    reset = 1'b1;
    chk_ctrl("rst_dwait", CRst);
    chk_st("rst_dwait", 2'd0, 16'd0);
    tick();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk_ctrl("post_rst", CNorm);
    tick();
    chk_st("post_rst", 2'd0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 id_rs1_index, id_rs2_index  in  5 each  source register indices of the instruction in ID.
REQ-004 ex_rgD_index  in  5  destination index held in ID/EX.
REQ-005 ex_mem_read  in  1  instruction in EX is a load.
REQ-006 branch_taken  in  1  branch resolved taken, from EX/M outputs (branch control AND ALU_zero).
REQ-007 imem_ready  in  1  instruction fetch completes this cycle.
REQ-008 dmem_req, dmem_ready  in  1 each  M-stage access pending / completes this cycle.
REQ-009 stall_clear  in  1  synchronous clear of stall_cycles.
REQ-010 pc_write, if_id_write, id_ex_write, ex_m_write, m_wb_write  out  1 each  write enables of the PC and the four pipeline registers.
REQ-011 if_id_flush, id_ex_flush, ex_m_flush, m_wb_flush  out  1 each  register loads a bubble (all zero) when write and flush are both 1.
REQ-012 pc_sel_target  out  1  PC loads the branch target instead of next_pc.
REQ-013 imem_abort  out  1  one-cycle pulse that cancels an outstanding fetch.
REQ-014 state  out  2  current FSM state; stall_cycles  out  16  saturating stall counter.

Function
REQ-015 The FSM SHALL have states RUN=0, IWAIT=1 and DWAIT=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-016 The load-use condition SHALL be ex_mem_read=1 AND ex_rgD_index!=0 AND ex_rgD_index equal to id_rs1_index or id_rs2_index.
REQ-017 Per-cycle priority in RUN and IWAIT SHALL be: dmem miss > branch_taken > load-use > imem not ready > normal advance.
REQ-018 Dmem miss (dmem_req=1, dmem_ready=0): pc, if_id, id_ex and ex_m writes=0; m_wb_write=1 with m_wb_flush=1; next state DWAIT.
REQ-019 In DWAIT with dmem_ready=0 the outputs SHALL match REQ-018 and all other inputs, branch_taken included, SHALL be ignored.
REQ-020 In DWAIT with dmem_ready=1 all writes=1, no flushes, next state RUN; a pending fetch is re-evaluated in RUN on the following cycle.
REQ-021 branch_taken: all writes=1, pc_sel_target=1, and if_id_flush, id_ex_flush and ex_m_flush=1; next state RUN; imem_abort=1 if the current state is IWAIT.
REQ-022 Load-use: pc_write=0, if_id_write=0, id_ex_flush=1, remaining writes=1; exactly one bubble per hazard, with no state change.
REQ-023 imem_ready=0 (no higher-priority event): pc_write=0, if_id_flush=1, downstream writes=1; next state IWAIT; IWAIT exits to RUN in the cycle imem_ready=1, with normal advance.
REQ-024 Normal advance: all writes=1, all flushes=0, pc_sel_target=0.
REQ-025 stall_cycles SHALL increment by 1 in every cycle with pc_write=0 and saturate at 16'hFFFF; stall_clear=1 SHALL load 0, overriding the increment.
REQ-026 Writes, flushes, pc_sel_target and imem_abort SHALL be combinational from the current state and inputs (zero latency); state and stall_cycles SHALL be registered.

Reset
REQ-027 While reset=1: state=RUN, stall_cycles=0, all writes=0, all flushes=1, pc_sel_target=0, imem_abort=0.
REQ-028 Reset asserted mid-DWAIT or mid-IWAIT SHALL abandon the wait without an imem_abort pulse; the first cycle after release follows normal RUN rules.

Structure
REQ-029 Package pipe_ctrl_pkg SHALL hold the state type and encodings, the register-index width (5) and the counter width (16).
REQ-030 Load-use comparison SHALL be one combinational sub-module, hazard_detect; the FSM and the counter stay in pipeline_ctrl.

Verification
REQ-031 ex_mem_read=1, ex_rgD_index=5, id_rs2_index=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles 0->1.
REQ-032 Same as REQ-031 but ex_rgD_index=0 -> no stall, all writes=1.
REQ-033 dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> state DWAIT for 3 cycles with m_wb_flush=1, then RUN; stall_cycles=3.
REQ-034 IWAIT with branch_taken=1 -> imem_abort=1, pc_sel_target=1, if_id/id_ex/ex_m flushes=1, next state RUN.
REQ-035 branch_taken=1 together with a dmem miss -> DWAIT entered, no flushes, pc_sel_target=0; branch still applied after dmem_ready.
REQ-036 Drive 70000 stall cycles -> stall_cycles holds at 16'hFFFF; stall_clear=1 -> 0; reset asserted mid-DWAIT -> state=RUN asynchronously.
